// File: rtl/bubbledrive8_pwrmon_if.sv
// Board power-pin bundle: raw asynchronous pins in, conditioned status out.
// The conditioner takes the slave side; whoever drives the pins takes master.
interface bubbledrive8_pwrmon_if;
    logic       MRST_RAW;
    logic       PWRSTAT_RAW;
    logic       nMPSSEEN_RAW;
    logic       MRST_STB;
    logic       PWRSTAT_STB;
    logic       nMPSSEEN_STB;
    logic [1:0] MODE;
    logic       MODE_VALID;
    logic       MODE_CHG;
    logic [7:0] GLITCH_CNT;

    modport master (
        output MRST_RAW, PWRSTAT_RAW, nMPSSEEN_RAW,
        input  MRST_STB, PWRSTAT_STB, nMPSSEEN_STB, MODE, MODE_VALID, MODE_CHG, GLITCH_CNT
    );

    modport slave (
        input  MRST_RAW, PWRSTAT_RAW, nMPSSEEN_RAW,
        output MRST_STB, PWRSTAT_STB, nMPSSEEN_STB, MODE, MODE_VALID, MODE_CHG, GLITCH_CNT
    );
endinterface

// File: rtl/bubbledrive8_pwrmon.sv
// Synchronises and debounces MRST/PWRSTAT/nMPSSEEN into MCLK and presents MODE.
// Optional glitch counter is compiled in with `define PWRMON_GLITCHCNT_EN.
module bubbledrive8_pwrmon #(
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int CNT_W           = 16
) (
    input  logic                   MCLK,
    input  logic                   nRST,
    bubbledrive8_pwrmon_if.slave   pm
);
    localparam int                NIN     = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {INIT, RUN} state_t;

    // bit 0 = MRST, bit 1 = PWRSTAT, bit 2 = nMPSSEEN
    logic [NIN-1:0] raw;
    assign raw = {pm.nMPSSEEN_RAW, pm.PWRSTAT_RAW, pm.MRST_RAW};

    logic [NIN-1:0]            sync1_q, sync2_q;
    logic [NIN-1:0]            stb_q, stb_d;
    logic [NIN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]          settle_q, settle_d;
    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic                      valid_q, valid_d;
    logic                      chg_q, chg_d;
    logic [NIN-1:0]            glitch_hit;
    logic [NIN-1:0]            diff;

    assign diff = sync2_q ^ stb_q;

    always_comb begin
        stb_d      = stb_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        state_d    = state_q;
        valid_d    = valid_q;
        glitch_hit = '0;
        case (state_q)
            INIT: begin
                // Track the pins directly until they have been quiet long enough.
                stb_d = sync2_q;
                cnt_d = '0;
                if (|diff) begin
                    settle_d = '0;
                end else if (settle_q == CNT_MAX) begin
                    state_d  = RUN;
                    valid_d  = 1'b1;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            RUN: begin
                for (int i = 0; i < NIN; i++) begin
                    if (diff[i]) begin
                        if (cnt_q[i] == CNT_MAX) begin
                            stb_d[i] = sync2_q[i];
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end else begin
                        // Returned to the committed level before the count completed.
                        if (cnt_q[i] != '0) glitch_hit[i] = 1'b1;
                        cnt_d[i] = '0;
                    end
                end
            end
            default: state_d = INIT;
        endcase
        mode_d = {stb_d[1], stb_d[0]};
        chg_d  = (state_q == RUN) && (mode_d != mode_q);
    end

    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stb_q    <= '1;
            cnt_q    <= '0;
            settle_q <= '0;
            state_q  <= INIT;
            mode_q   <= 2'b11;
            valid_q  <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stb_q    <= stb_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            chg_q    <= chg_d;
        end
    end

`ifdef PWRMON_GLITCHCNT_EN
    logic [7:0] glitch_q, glitch_d;
    logic [8:0] glitch_sum;

    always_comb begin
        glitch_sum = 9'(glitch_q) + 9'(glitch_hit[0]) + 9'(glitch_hit[1]) + 9'(glitch_hit[2]);
        glitch_d   = (glitch_sum > 9'd255) ? 8'd255 : glitch_sum[7:0];
    end

    always_ff @(posedge MCLK) begin
        if (!nRST) glitch_q <= 8'd0;
        else       glitch_q <= glitch_d;
    end

    assign pm.GLITCH_CNT = glitch_q;
`else
    logic glitch_unused;
    assign glitch_unused = ^glitch_hit;
    assign pm.GLITCH_CNT = 8'd0;
`endif

    assign pm.MRST_STB     = stb_q[0];
    assign pm.PWRSTAT_STB  = stb_q[1];
    assign pm.nMPSSEEN_STB = stb_q[2];
    assign pm.MODE         = mode_q;
    assign pm.MODE_VALID   = valid_q;
    assign pm.MODE_CHG     = chg_q;
endmodule
